// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states and the queued {pc, instr} entry.
package riscv_fetch_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request path plus the decode-side valid/ready handshake.
interface instr_fetch_unit_if;
  import riscv_fetch_pkg::*;
  logic [INSTR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (output imem_addr, input imem_instr,
                  output if_valid, input if_ready, output if_pc, output if_instr);
  modport slave  (input imem_addr, output imem_instr,
                  input if_valid, output if_ready, input if_pc, input if_instr);
endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides push/pop in the same cycle.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_pop  = pop && !empty;
  // A full queue may still accept when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, run/idle/fault control and redirect handling ahead of the fetch queue.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                fetch_fault,
  instr_fetch_unit_if.master  bus
);
  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc;
  fetch_entry_t w_head, w_wr_entry;
  logic         w_full, w_empty, w_push, w_pop;
  logic         w_redir_ok, w_redir_bad;

  assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign w_pop       = !w_empty && bus.if_ready;
  // Any redirect, good or bad, suppresses the push of the now-stale fetch word.
  assign w_push      = (r_state == RUN) && fetch_en && !redirect_valid && (!w_full || w_pop);
  assign w_wr_entry  = '{pc: r_fetch_pc, instr: bus.imem_instr};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fetch_en)  w_state_nxt = RUN;
      RUN:     if (!fetch_en) w_state_nxt = IDLE;
      default: w_state_nxt = FAULT;
    endcase
    if (w_redir_bad) w_state_nxt = FAULT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir_ok && r_state != FAULT) r_fetch_pc <= redirect_pc;
      else if (w_push)                    r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (reset),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .wr_entry (w_wr_entry),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign bus.imem_addr = r_fetch_pc;
  assign bus.if_valid  = !w_empty;
  assign bus.if_pc     = w_head.pc;
  assign bus.if_instr  = w_head.instr;
  assign fetch_fault   = (r_state == FAULT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects, fault and PC wrap.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, fetch_fault;
  logic [31:0] redirect_pc;
  logic        rst2, fetch_en2, redirect_valid2, fetch_fault2;
  logic [31:0] redirect_pc2;
  int          n_pass = 0;
  int          n_total = 0;

  instr_fetch_unit_if bif();
  instr_fetch_unit_if bif2();

  function automatic logic [31:0] rom(input logic [29:0] w);
    if (w >= 30'd64) return 32'h0000_0013;
    case (w)
      30'd0:   return 32'h0050_0093;
      30'd1:   return 32'h00A0_0113;
      30'd2:   return 32'h0020_81B3;
      30'd3:   return 32'h0030_0023;
      default: return {24'hA0_0000, 2'b00, w[5:0]};
    endcase
  endfunction

  assign bif.imem_instr  = rom(bif.imem_addr[31:2]);
  assign bif2.imem_instr = rom(bif2.imem_addr[31:2]);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
    .clk(clk), .reset(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault), .bus(bif.master));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) u_dut_wrap (
    .clk(clk), .reset(rst2), .fetch_en(fetch_en2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .fetch_fault(fetch_fault2), .bus(bif2.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bif.if_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bif.if_ready = 1'b0;
    tick();
    n_total++; if (bif.if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bif.if_valid); else n_pass++;
    n_total++; if (bif.if_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bif.if_pc); else n_pass++;
    n_total++; if (bif.if_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", bif.if_instr); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else n_pass++;
    n_total++; if (bif.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bif.imem_addr); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_in = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0030_0023};
    do_reset();
    fetch_en = 1'b1; bif.if_ready = 1'b1;
    tick();  // IDLE -> RUN edge
    n_total++; if (bif.if_valid !== 1'b0) $display("FAIL stream_first_edge_valid: got %b want 0", bif.if_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (bif.if_valid !== 1'b1 || bif.if_pc !== exp_pc[i] || bif.if_instr !== exp_in[i])
        $display("FAIL stream_%0d: got v=%b pc=%h in=%h want v=1 pc=%h in=%h",
                 i, bif.if_valid, bif.if_pc, bif.if_instr, exp_pc[i], exp_in[i]);
      else n_pass++;
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; bif.if_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    n_total++; if (bif.imem_addr !== 32'h8) $display("FAIL bp_addr_stuck: got %h want 8", bif.imem_addr); else n_pass++;
    n_total++; if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h0) $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", bif.if_valid, bif.if_pc); else n_pass++;
    bif.if_ready = 1'b1;
    tick();
    n_total++; if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h4) $display("FAIL bp_drain1: got v=%b pc=%h want v=1 pc=4", bif.if_valid, bif.if_pc); else n_pass++;
    tick();
    n_total++; if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h8 || bif.if_instr !== 32'h0020_81B3)
      $display("FAIL bp_drain2: got v=%b pc=%h in=%h want v=1 pc=8 in=002081b3", bif.if_valid, bif.if_pc, bif.if_instr); else n_pass++;
    tick();
    n_total++; if (bif.if_pc !== 32'hC) $display("FAIL bp_drain3: got pc=%h want c", bif.if_pc); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; bif.if_ready = 1'b0;
    tick(); tick(); tick();  // queue holds pc 0 and 4
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (bif.if_valid !== 1'b0) $display("FAIL redir8_bubble: got %b want 0", bif.if_valid); else n_pass++;
    n_total++; if (bif.imem_addr !== 32'h8) $display("FAIL redir8_addr: got %h want 8", bif.imem_addr); else n_pass++;
    bif.if_ready = 1'b1;
    tick();
    n_total++; if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h8 || bif.if_instr !== 32'h0020_81B3)
      $display("FAIL redir8_target: got v=%b pc=%h in=%h want v=1 pc=8 in=002081b3", bif.if_valid, bif.if_pc, bif.if_instr); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (bif.if_valid !== 1'b0) $display("FAIL redir100_bubble: got %b want 0", bif.if_valid); else n_pass++;
    tick();
    n_total++; if (bif.if_pc !== 32'h100 || bif.if_instr !== 32'h13) $display("FAIL redir100_e0: got pc=%h in=%h want pc=100 in=13", bif.if_pc, bif.if_instr); else n_pass++;
    tick();
    n_total++; if (bif.if_pc !== 32'h104 || bif.if_instr !== 32'h13) $display("FAIL redir100_e1: got pc=%h in=%h want pc=104 in=13", bif.if_pc, bif.if_instr); else n_pass++;
  endtask

  task automatic test_fault();
    // continues from test_redirect: fetch_pc is 0x108 here
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fetch_fault); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", fetch_fault); else n_pass++;
    n_total++; if (bif.if_valid !== 1'b0) $display("FAIL fault_valid: got %b want 0", bif.if_valid); else n_pass++;
    n_total++; if (bif.imem_addr !== 32'h108) $display("FAIL fault_addr_frozen: got %h want 108", bif.imem_addr); else n_pass++;
    do_reset();
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL fault_cleared: got %b want 0", fetch_fault); else n_pass++;
    n_total++; if (bif.imem_addr !== 32'h0) $display("FAIL fault_reset_pc: got %h want 0", bif.imem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1; fetch_en2 = 1'b0; bif2.if_ready = 1'b1;
    tick();
    n_total++; if (bif2.imem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_reset_pc: got %h want fffffff8", bif2.imem_addr); else n_pass++;
    rst2 = 1'b0; fetch_en2 = 1'b1;
    tick(); tick();
    n_total++; if (bif2.if_pc !== 32'hFFFF_FFF8 || bif2.if_instr !== 32'h13) $display("FAIL wrap_e0: got pc=%h in=%h want pc=fffffff8 in=13", bif2.if_pc, bif2.if_instr); else n_pass++;
    tick();
    n_total++; if (bif2.if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_e1: got pc=%h want fffffffc", bif2.if_pc); else n_pass++;
    tick();
    n_total++; if (bif2.if_pc !== 32'h0 || bif2.if_instr !== 32'h0050_0093) $display("FAIL wrap_e2: got pc=%h in=%h want pc=0 in=00500093", bif2.if_pc, bif2.if_instr); else n_pass++;
    #2 rst2 = 1'b1;
    #1;
    n_total++; if (bif2.if_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", bif2.if_valid); else n_pass++;
    n_total++; if (bif2.imem_addr !== 32'hFFFF_FFF8) $display("FAIL async_reset_pc: got %h want fffffff8", bif2.imem_addr); else n_pass++;
    tick();
    rst2 = 1'b0; fetch_en2 = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1; fetch_en2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0; bif2.if_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
